apb_ram_slave: RTL and testbench



---
 rtl/apb_pkg.sv | 34 +++
 rtl/apb_ram_mem.sv | 44 ++++
 rtl/apb_ram_slave.sv | 124 ++++++++++++
 tb/tb_apb_ram_slave.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB widths, FSM state encoding and the byte-lane merge helper
// used by the RAM slave and its storage array.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = APB_DATA_W / 8;
  localparam int APB_PROT_W = 3;
  localparam int APB_WAIT_W = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // Replace only the byte lanes whose strobe bit is set
  function automatic logic [APB_DATA_W-1:0] apb_merge(
    input logic [APB_DATA_W-1:0] old_w,
    input logic [APB_DATA_W-1:0] new_w,
    input logic [APB_STRB_W-1:0] strb
  );
    logic [APB_DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < APB_STRB_W; i++) begin
      if (strb[i]) begin
        res[i*8 +: 8] = new_w[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_w[i*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_ram_mem.sv
// Byte-lane-enable synchronous RAM: one strobed write port and one read
// port whose output register loads on request and clears on reset.
module apb_ram_mem
  import apb_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [APB_DATA_W-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [APB_DATA_W-1:0] wr_data,
  input  logic [APB_STRB_W-1:0] wr_strb
);

  logic [APB_DATA_W-1:0] mem_r [DEPTH];
  logic [APB_DATA_W-1:0] rd_data_r;

  // Storage array; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_idx] <= apb_merge(mem_r[wr_idx], wr_data, wr_strb);
    end
  end

  // Read data register; zero is loaded for rejected accesses
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= '0;
    end else if (rd_en) begin
      rd_data_r <= rd_zero ? '0 : mem_r[rd_idx];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/apb_ram_slave.sv
// APB slave fronting a word-addressed RAM with programmable wait states,
// alignment/range/privilege error decode and protocol-abort handling.
module apb_ram_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_W,
  parameter int DATA_WIDTH  = APB_DATA_W,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int PROT_WIDTH  = APB_PROT_W,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  input  logic [PROT_WIDTH-1:0] PPROT,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int                    IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);
  localparam logic [APB_WAIT_W-1:0] WAIT_LD    = APB_WAIT_W'(WAIT_CYCLES);

  apb_state_e            state_r, state_s;
  logic [APB_WAIT_W-1:0] cnt_r, cnt_s;
  logic                  err_r, wr_r;
  logic [IDX_W-1:0]      idx_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [STRB_WIDTH-1:0] strb_r;

  logic setup_s, err_s, done_s, pready_s, mem_we_s;
  logic unused_prot_s;

  assign setup_s  = (state_r == IDLE) && PSEL && !PENABLE;
  assign err_s    = (PADDR[1:0] != 2'b00) || ({1'b0, PADDR} >= ADDR_LIMIT) ||
                    (PWRITE && !PPROT[0]);
  assign done_s   = (state_r == ACCESS) && PSEL && PENABLE && (cnt_r == 4'd0);
  // A reset edge must never coincide with a completion or commit
  assign pready_s = done_s && !PRESET;
  assign mem_we_s = pready_s && wr_r && !err_r;
  assign unused_prot_s = ^PPROT[PROT_WIDTH-1:1];

  // Next-state and wait-counter decode
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (setup_s) begin
          state_s = ACCESS;
          cnt_s   = WAIT_LD;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_s = IDLE;
        end else if (PENABLE) begin
          if (cnt_r != 4'd0) begin
            cnt_s = cnt_r - 4'd1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = ACCESS;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, counter and setup-phase capture registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      err_r   <= 1'b0;
      wr_r    <= 1'b0;
      idx_r   <= '0;
      wdata_r <= '0;
      strb_r  <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (setup_s) begin
        err_r   <= err_s;
        wr_r    <= PWRITE;
        idx_r   <= PADDR[IDX_W+1:2];
        wdata_r <= PWDATA;
        strb_r  <= PSTRB;
      end
    end
  end

  apb_ram_mem #(
    .DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk     (PCLK),
    .rst     (PRESET),
    .rd_en   (setup_s && !PWRITE),
    .rd_zero (err_s),
    .rd_idx  (PADDR[IDX_W+1:2]),
    .rd_data (PRDATA),
    .wr_en   (mem_we_s),
    .wr_idx  (idx_r),
    .wr_data (wdata_r),
    .wr_strb (strb_r)
  );

  assign PREADY  = pready_s;
  assign PSLVERR = pready_s && err_r;

endmodule

// File: tb/tb_apb_ram_slave.sv
// Directed bench for apb_ram_slave: three instances (0, 3 and 2 wait
// states) share the APB bus signals and are selected by their own PSEL.
module tb_apb_ram_slave;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel0, psel3, psel2;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready0, pready3, pready2;
  logic        pslverr0, pslverr3, pslverr2;
  logic [31:0] prdata0, prdata3, prdata2;

  int          sel_v = 0;
  logic        cur_ready, cur_err;
  logic [31:0] cur_rdata;
  int          cyc = 0;
  int          ready_cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_ram_slave #(.WAIT_CYCLES(0)) u_dut0 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0));

  apb_ram_slave #(.WAIT_CYCLES(3)) u_dut3 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PREADY(pready3), .PRDATA(prdata3), .PSLVERR(pslverr3));

  apb_ram_slave #(.WAIT_CYCLES(2)) u_dut2 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel2), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PREADY(pready2), .PRDATA(prdata2), .PSLVERR(pslverr2));

  always_comb begin
    case (sel_v)
      1:       begin cur_ready = pready3; cur_err = pslverr3; cur_rdata = prdata3; end
      2:       begin cur_ready = pready2; cur_err = pslverr2; cur_rdata = prdata2; end
      default: begin cur_ready = pready0; cur_err = pslverr0; cur_rdata = prdata0; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_sel(input int sel, input logic v);
    sel_v = sel;
    psel0 = (sel == 0) ? v : 1'b0;
    psel3 = (sel == 1) ? v : 1'b0;
    psel2 = (sel == 2) ? v : 1'b0;
  endtask

  // Called #1 after a rising edge; returns #1 after the completion edge.
  task automatic apb_xfer(input int sel, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input logic [2:0] prot, output logic [31:0] rdata,
                          output logic err, output int acc);
    logic done;
    drive_sel(sel, 1'b1);
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb; pprot = prot;
    @(posedge pclk); #1;
    penable = 1'b1;
    acc = 0; rdata = '0; err = 1'b0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge pclk);
      acc++;
      if (cur_ready) begin
        rdata = cur_rdata; err = cur_err; done = 1'b1; ready_cyc = cyc;
      end
      @(posedge pclk); #1;
    end
    chk("xfer_done", {31'd0, done}, 32'd1);
    drive_sel(sel, 1'b0);
    penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          acc, first_cyc;

    preset = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    pstrb = 4'h0; pprot = 3'b000;
    drive_sel(0, 1'b0);
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    chk("rst_pready",  {31'd0, pready0},  32'd0);
    chk("rst_pslverr", {31'd0, pslverr0}, 32'd0);
    chk("rst_prdata",  prdata0,           32'd0);
    chk("rst_prdata3", prdata3,           32'd0);
    @(posedge pclk); #1;

    // Basic write/read, zero wait states
    apb_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, acc);
    chk("w10_acc", acc, 32'd1);
    chk("w10_err", {31'd0, er}, 32'd0);
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b001, rd, er, acc);
    chk("r10_acc", acc, 32'd1);
    chk("r10_data", rd, 32'hDEADBEEF);
    chk("r10_err", {31'd0, er}, 32'd0);

    // Partial strobe and empty strobe
    apb_xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 3'b001, rd, er, acc);
    apb_xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 3'b001, rd, er, acc);
    apb_xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er, acc);
    chk("strb_data", rd, 32'h11BB33DD);
    apb_xfer(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 3'b001, rd, er, acc);
    chk("strb0_err", {31'd0, er}, 32'd0);
    apb_xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er, acc);
    chk("strb0_data", rd, 32'h11BB33DD);

    // Error cases
    apb_xfer(0, 1'b0, 32'h400, 32'h0, 4'h0, 3'b001, rd, er, acc);
    chk("oor_err", {31'd0, er}, 32'd1);
    chk("oor_data", rd, 32'h0);
    apb_xfer(0, 1'b1, 32'h00, 32'h01020304, 4'hF, 3'b001, rd, er, acc);
    apb_xfer(0, 1'b1, 32'h02, 32'hFFFFFFFF, 4'hF, 3'b001, rd, er, acc);
    chk("unal_err", {31'd0, er}, 32'd1);
    apb_xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 3'b001, rd, er, acc);
    chk("unal_mem", rd, 32'h01020304);
    apb_xfer(0, 1'b1, 32'h10, 32'h00000000, 4'hF, 3'b000, rd, er, acc);
    chk("prot_err", {31'd0, er}, 32'd1);
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, er, acc);
    chk("prot_rderr", {31'd0, er}, 32'd0);
    chk("prot_mem", rd, 32'hDEADBEEF);

    // Highest legal word
    apb_xfer(0, 1'b1, 32'h3FC, 32'h600DCAFE, 4'hF, 3'b001, rd, er, acc);
    chk("top_werr", {31'd0, er}, 32'd0);
    apb_xfer(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 3'b001, rd, er, acc);
    chk("top_data", rd, 32'h600DCAFE);

    // Back-to-back write then read, no idle cycle between
    apb_xfer(0, 1'b1, 32'h0C, 32'h0C0FFEE0, 4'hF, 3'b001, rd, er, acc);
    first_cyc = ready_cyc;
    apb_xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b001, rd, er, acc);
    chk("b2b_data", rd, 32'h0C0FFEE0);
    chk("b2b_gap", ready_cyc - first_cyc, 32'd2);

    // Three wait states
    apb_xfer(1, 1'b1, 32'h04, 32'h44444444, 4'hF, 3'b001, rd, er, acc);
    chk("w3_acc", acc, 32'd4);
    apb_xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 3'b001, rd, er, acc);
    chk("r3_acc", acc, 32'd4);
    chk("r3_data", rd, 32'h44444444);

    // PSEL abort during a waited write
    apb_xfer(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 3'b001, rd, er, acc);
    drive_sel(1, 1'b1);
    penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'h55555555; pstrb = 4'hF; pprot = 3'b001;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1;
    drive_sel(1, 1'b0); penable = 1'b0;
    @(negedge pclk);
    chk("abort_rdy", {31'd0, pready3}, 32'd0);
    repeat (4) @(posedge pclk);
    #1;
    apb_xfer(1, 1'b0, 32'h30, 32'h0, 4'h0, 3'b001, rd, er, acc);
    chk("abort_mem", rd, 32'hCAFEF00D);

    // Reset in the middle of a two-wait-state write
    apb_xfer(2, 1'b1, 32'h08, 32'h0BADF00D, 4'hF, 3'b001, rd, er, acc);
    chk("w2_acc", acc, 32'd3);
    apb_xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, acc);
    chk("r2_data", rd, 32'h0BADF00D);
    drive_sel(2, 1'b1);
    penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h12345678; pstrb = 4'hF; pprot = 3'b001;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 preset = 1'b1;
    @(posedge pclk); #1 preset = 1'b0;
    drive_sel(2, 1'b0); penable = 1'b0;
    @(negedge pclk);
    chk("rstm_rdy",  {31'd0, pready2},  32'd0);
    chk("rstm_err",  {31'd0, pslverr2}, 32'd0);
    chk("rstm_data", prdata2,           32'd0);
    @(posedge pclk); #1;
    apb_xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, acc);
    chk("rstm_mem", rd, 32'h0BADF00D);
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b001, rd, er, acc);
    chk("rst_keep", rd, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
